// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Holds FSM states, opcodes, ALUControl codes, ImmSrc and mux-select encodings.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        JALR     = 4'd10,
        BRANCH   = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format needed by DECODE to form the OldPC-relative target.
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:          imm_src_for = IMM_S;
            OP_BRANCH:         imm_src_for = IMM_B;
            OP_JAL:            imm_src_for = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src_for = IMM_U;
            default:           imm_src_for = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALUControl decode from funct3/funct7_5 for register and immediate ALU ops.
// funct7_5 selects SUB only for register ops, but selects SRA for both forms.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_reg,
    output logic [3:0] alu_control
);

    // Map funct3 (and funct7_5 where meaningful) to an ALU operation.
    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller_branch_cond.sv
// Branch-taken evaluation from funct3 and the flags of SrcA-SrcB.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       N,
    input  logic       C,
    input  logic       V,
    output logic       taken
);

    // Reserved encodings 010/011 never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = N ^ V;
            3'b101:  taken = ~(N ^ V);
            3'b110:  taken = C;
            3'b111:  taken = ~C;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory, single-ALU multicycle RV32I datapath.
// All outputs decode combinationally from the state register (plus mem_ready/flags/IR fields).
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int IMM_SRC_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7_5,
    input  logic                      Zero,
    input  logic                      N,
    input  logic                      C,
    input  logic                      V,
    input  logic                      mem_ready,
    output logic                      mem_req,
    output logic                      MemWrite,
    output logic                      AdrSrc,
    output logic                      IRWrite,
    output logic                      PCWrite,
    output logic                      RegWrite,
    output logic [1:0]                ResultSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
    output logic                      illegal_instr
);

    state_t     state_r;
    state_t     next_state_s;
    logic       taken_s;
    logic [3:0] alu_dec_s;
    logic [3:0] alu_s;
    logic [2:0] imm_s;

    branch_cond u_branch_cond (
        .funct3 (funct3[2:0]),
        .Zero   (Zero),
        .N      (N),
        .C      (C),
        .V      (V),
        .taken  (taken_s)
    );

    alu_decoder u_alu_decoder (
        .funct3      (funct3[2:0]),
        .funct7_5    (funct7_5),
        .is_reg      (op[5]),
        .alu_control (alu_dec_s)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        next_state_s  = FETCH;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        alu_s         = ALU_ADD;
        imm_s         = IMM_I;
        illegal_instr = 1'b0;
        case (state_r)
            FETCH: begin
                mem_req      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                IRWrite      = mem_ready;
                PCWrite      = mem_ready;
                next_state_s = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                imm_s   = imm_src_for(op[6:0]);
                case (op[6:0])
                    OP_LOAD, OP_STORE: next_state_s = MEMADR;
                    OP_R:              next_state_s = EXECR;
                    OP_I:              next_state_s = EXECI;
                    OP_JAL:            next_state_s = JAL;
                    OP_JALR:           next_state_s = JALR;
                    OP_BRANCH:         next_state_s = BRANCH;
                    OP_LUI:            next_state_s = LUI;
                    OP_AUIPC:          next_state_s = AUIPC;
                    default: begin
                        next_state_s  = FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                imm_s        = (op[6:0] == OP_STORE) ? IMM_S : IMM_I;
                next_state_s = (op[6:0] == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                next_state_s = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc    = RES_DATA;
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                mem_req      = 1'b1;
                MemWrite     = 1'b1;
                AdrSrc       = 1'b1;
                next_state_s = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA      = SRCA_RD1;
                alu_s        = alu_dec_s;
                next_state_s = ALUWB;
            end
            EXECI: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                alu_s        = alu_dec_s;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                RegWrite     = 1'b1;
                next_state_s = FETCH;
            end
            JALR: begin
                ALUSrcA      = SRCA_RD1;
                ALUSrcB      = SRCB_IMM;
                next_state_s = JAL;
            end
            JAL: begin
                // PC takes the target already in ALUOut while ALUOut captures the link value.
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                PCWrite      = 1'b1;
                next_state_s = ALUWB;
            end
            BRANCH: begin
                ALUSrcA      = SRCA_RD1;
                alu_s        = ALU_SUB;
                PCWrite      = taken_s;
                next_state_s = FETCH;
            end
            LUI: begin
                ALUSrcA      = SRCA_ZERO;
                ALUSrcB      = SRCB_IMM;
                imm_s        = IMM_U;
                next_state_s = ALUWB;
            end
            AUIPC: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_IMM;
                imm_s        = IMM_U;
                next_state_s = ALUWB;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    assign ALUControl = ALU_CTRL_WIDTH'(alu_s);
    assign ImmSrc     = IMM_SRC_WIDTH'(imm_s);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench: driver pushes hand-computed per-cycle output words, monitor pops and compares.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       Zero = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .N(N), .C(C), .V(V), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Staged inputs applied at the next falling edge.
    logic       s_rst = 1'b0;
    logic [6:0] s_op = 7'd0;
    logic [2:0] s_f3 = 3'd0;
    logic       s_f75 = 1'b0;
    logic [3:0] s_flags = 4'd0;  // {Zero,N,C,V}

    wire [19:0] act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr};

    function automatic logic [19:0] pk(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [3:0] alu,
                                       input logic [2:0] imm, input logic ill);
        return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    // Hand-derived expected output words per state.
    function automatic logic [19:0] e_fetch(input logic mr);
        return pk(1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 3'b000, 1'b0);
    endfunction
    function automatic logic [19:0] e_decode(input logic [2:0] imm, input logic ill);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'd0, imm, ill);
    endfunction
    function automatic logic [19:0] e_memadr(input logic [2:0] imm);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'd0, imm, 1'b0);
    endfunction
    function automatic logic [19:0] e_execr(input logic [3:0] alu);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 1'b0);
    endfunction
    function automatic logic [19:0] e_execi(input logic [3:0] alu);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 1'b0);
    endfunction
    function automatic logic [19:0] e_branch(input logic t);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, t, 1'b0, 2'b00, 2'b10, 2'b00, 4'd1, 3'b000, 1'b0);
    endfunction

    logic [19:0] E_MEMREAD, E_MEMWB, E_MEMWRITE, E_ALUWB, E_JALR, E_JAL, E_LUI, E_AUIPC;
    initial begin
        E_MEMREAD  = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b000, 1'b0);
        E_MEMWB    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 4'd0, 3'b000, 1'b0);
        E_MEMWRITE = pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 3'b000, 1'b0);
        E_ALUWB    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 3'b000, 1'b0);
        E_JALR     = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'd0, 3'b000, 1'b0);
        E_JAL      = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 4'd0, 3'b000, 1'b0);
        E_LUI      = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 4'd0, 3'b100, 1'b0);
        E_AUIPC    = pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'd0, 3'b100, 1'b0);
    end

    task automatic cyc(input logic mr, input logic [19:0] e, input string nm);
        @(negedge clk);
        rst_n     = s_rst;
        op        = s_op;
        funct3    = s_f3;
        funct7_5  = s_f75;
        {Zero, N, C, V} = s_flags;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                         input logic [3:0] fl);
        s_op = o; s_f3 = f3; s_f75 = f75; s_flags = fl;
    endtask

    // Monitor: compare every cycle that the driver has issued an expectation for.
    initial begin
        logic [19:0] e;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (act !== e) begin
                    n_err++;
                    $display("FAIL %s: got %05h expected %05h", nm, act, e);
                end
            end
        end
    end

    initial begin
        // Reset held: FETCH outputs, IRWrite/PCWrite follow mem_ready.
        cyc(1'b1, e_fetch(1'b1), "reset_fetch");
        s_rst = 1'b1;

        // add x3,x1,x2
        instr(7'b0110011, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "add_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "add_decode");
        cyc(1'b1, e_execr(4'd0), "add_execr");
        cyc(1'b1, E_ALUWB, "add_aluwb");

        // sub and sra register forms
        instr(7'b0110011, 3'b000, 1'b1, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "sub_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "sub_decode");
        cyc(1'b1, e_execr(4'd1), "sub_execr");
        cyc(1'b1, E_ALUWB, "sub_aluwb");
        instr(7'b0110011, 3'b101, 1'b1, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "sra_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "sra_decode");
        cyc(1'b1, e_execr(4'd9), "sra_execr");
        cyc(1'b1, E_ALUWB, "sra_aluwb");

        // addi with IR[30] set must stay ADD; srai honours it
        instr(7'b0010011, 3'b000, 1'b1, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "addi_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "addi_decode");
        cyc(1'b1, e_execi(4'd0), "addi_execi");
        cyc(1'b1, E_ALUWB, "addi_aluwb");
        instr(7'b0010011, 3'b101, 1'b1, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "srai_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "srai_decode");
        cyc(1'b1, e_execi(4'd9), "srai_execi");
        cyc(1'b1, E_ALUWB, "srai_aluwb");

        // lw with fetch stall and 2 stall cycles in MEMREAD
        instr(7'b0000011, 3'b010, 1'b0, 4'b0000);
        cyc(1'b0, e_fetch(1'b0), "lw_fetch_stall");
        cyc(1'b1, e_fetch(1'b1), "lw_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "lw_decode");
        cyc(1'b1, e_memadr(3'b000), "lw_memadr");
        cyc(1'b0, E_MEMREAD, "lw_memread0");
        cyc(1'b0, E_MEMREAD, "lw_memread1");
        cyc(1'b1, E_MEMREAD, "lw_memread2");
        cyc(1'b1, E_MEMWB, "lw_memwb");

        // sw with 3 stall cycles: MemWrite for exactly 4 cycles
        instr(7'b0100011, 3'b010, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "sw_fetch");
        cyc(1'b1, e_decode(3'b001, 1'b0), "sw_decode");
        cyc(1'b1, e_memadr(3'b001), "sw_memadr");
        cyc(1'b0, E_MEMWRITE, "sw_memwrite0");
        cyc(1'b0, E_MEMWRITE, "sw_memwrite1");
        cyc(1'b0, E_MEMWRITE, "sw_memwrite2");
        cyc(1'b1, E_MEMWRITE, "sw_memwrite3");

        // blt N=1 V=0 taken
        instr(7'b1100011, 3'b100, 1'b0, 4'b0100);
        cyc(1'b1, e_fetch(1'b1), "sw_done_blt_fetch");
        cyc(1'b1, e_decode(3'b010, 1'b0), "blt_decode");
        cyc(1'b1, e_branch(1'b1), "blt_branch");
        // bgeu C=1 not taken
        instr(7'b1100011, 3'b111, 1'b0, 4'b0010);
        cyc(1'b1, e_fetch(1'b1), "bgeu_fetch");
        cyc(1'b1, e_decode(3'b010, 1'b0), "bgeu_decode");
        cyc(1'b1, e_branch(1'b0), "bgeu_branch");
        // beq Zero=1 taken; reserved funct3 010 never taken
        instr(7'b1100011, 3'b000, 1'b0, 4'b1000);
        cyc(1'b1, e_fetch(1'b1), "beq_fetch");
        cyc(1'b1, e_decode(3'b010, 1'b0), "beq_decode");
        cyc(1'b1, e_branch(1'b1), "beq_branch");
        instr(7'b1100011, 3'b010, 1'b0, 4'b1111);
        cyc(1'b1, e_fetch(1'b1), "b010_fetch");
        cyc(1'b1, e_decode(3'b010, 1'b0), "b010_decode");
        cyc(1'b1, e_branch(1'b0), "b010_branch");

        // jalr
        instr(7'b1100111, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "jalr_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b0), "jalr_decode");
        cyc(1'b1, E_JALR, "jalr_jalr");
        cyc(1'b1, E_JAL, "jalr_jal");
        cyc(1'b1, E_ALUWB, "jalr_aluwb");
        // jal
        instr(7'b1101111, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "jal_fetch");
        cyc(1'b1, e_decode(3'b011, 1'b0), "jal_decode");
        cyc(1'b1, E_JAL, "jal_jal");
        cyc(1'b1, E_ALUWB, "jal_aluwb");
        // lui / auipc
        instr(7'b0110111, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "lui_fetch");
        cyc(1'b1, e_decode(3'b100, 1'b0), "lui_decode");
        cyc(1'b1, E_LUI, "lui_lui");
        cyc(1'b1, E_ALUWB, "lui_aluwb");
        instr(7'b0010111, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "auipc_fetch");
        cyc(1'b1, e_decode(3'b100, 1'b0), "auipc_decode");
        cyc(1'b1, E_AUIPC, "auipc_auipc");
        cyc(1'b1, E_ALUWB, "auipc_aluwb");

        // illegal opcode: single pulse in DECODE, then FETCH
        instr(7'b0000000, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_fetch(1'b1), "ill_fetch");
        cyc(1'b1, e_decode(3'b000, 1'b1), "ill_decode");
        cyc(1'b1, e_fetch(1'b1), "ill_back_fetch");

        // Reset mid-MEMWRITE: store strobe drops in the same cycle
        instr(7'b0100011, 3'b000, 1'b0, 4'b0000);
        cyc(1'b1, e_decode(3'b001, 1'b0), "rst_sw_decode");
        cyc(1'b1, e_memadr(3'b001), "rst_sw_memadr");
        cyc(1'b0, E_MEMWRITE, "rst_sw_memwrite");
        s_rst = 1'b0;
        cyc(1'b0, e_fetch(1'b0), "rst_abort_fetch");
        cyc(1'b1, e_fetch(1'b1), "rst_hold_fetch");
        s_rst = 1'b1;
        cyc(1'b1, e_fetch(1'b1), "rst_release_fetch");
        cyc(1'b1, e_decode(3'b001, 1'b0), "post_rst_decode");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM sequencing a shared-memory, single-ALU multicycle RV32I datapath (PC, OldPC, IR, Data, ALUOut registers).
- Replaces the single-cycle control unit when the core is built multicycle.
- Issues per-state mux selects, register enables and memory requests, and evaluates branch conditions from ALU flags.
- Stalls on a memory ready handshake.

Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 4, ALUControl width
- IMM_SRC_WIDTH, 3, ImmSrc width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  OP_WIDTH  opcode from IR
- funct3  in  FUNCT3_WIDTH  from IR
- funct7_5  in  1  IR[30]
- Zero, N, C, V  in  1 each  ALU flags for SrcA-SrcB; C=1 means SrcA<SrcB unsigned
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store strobe
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUControl  out  ALU_CTRL_WIDTH  ALU operation
- ImmSrc  out  IMM_SRC_WIDTH  000 I, 001 S, 010 B, 011 J, 100 U
- illegal_instr  out  1  one-cycle pulse on an unrecognised opcode

Behaviour:
- Reset: state=FETCH, asserted asynchronously on rst_n low and released synchronously.
- Reset outputs, all combinational from the state register:
  - mem_req=1; ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - All other outputs 0; IRWrite and PCWrite follow mem_ready.
- Reset mid-instruction aborts it immediately; MemWrite drops in the same cycle.
- Unlisted outputs are 0 in each state. ALUControl=ADD unless stated.
- FETCH: mem_req=1, AdrSrc=0, SrcA=00, SrcB=10, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay while !mem_ready; otherwise go to DECODE.
- DECODE: SrcA=01, SrcB=01, ImmSrc from op (computes OldPC+imm into ALUOut).
  - load/store -> MEMADR; R -> EXECR; I-ALU -> EXECI; JAL -> JAL; JALR -> JALR.
  - branch -> BRANCH; LUI -> LUI; AUIPC -> AUIPC.
  - Any other opcode -> FETCH with illegal_instr=1.
- MEMADR: SrcA=10, SrcB=01, ImmSrc I (load) or S (store). Next: load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00.
  - Both held until mem_ready, then go to FETCH.
  - Exactly one store is accepted.
- EXECR: SrcA=10, SrcB=00, ALUControl from op/funct3/funct7_5, then go to ALUWB.
- EXECI: SrcA=10, SrcB=01, ImmSrc I, ALUControl from funct3.
  - funct7_5 is honoured only for SRAI.
  - Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
- JALR: SrcA=10, SrcB=01, ImmSrc I (target into ALUOut), then go to JAL.
- JAL: SrcA=01, SrcB=10, ResultSrc=00, PCWrite=1 (PC<=target, ALUOut<=OldPC+4), then go to ALUWB.
- BRANCH: SrcA=10, SrcB=00, ALUControl=SUB, ResultSrc=00, PCWrite=taken, then go to FETCH.
  - beq Zero; bne ~Zero; blt N^V; bge ~(N^V); bltu C; bgeu ~C.
  - funct3 010/011: not taken.
- LUI: SrcA=11, SrcB=01, ImmSrc U, then go to ALUWB.
- AUIPC: SrcA=01, SrcB=01, ImmSrc U, then go to ALUWB.
- Cycle counts with mem_ready tied 1:
  - branch 3; R/I/store/LUI/AUIPC 4; JAL 4; load 5; JALR 5.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.

Decomposition:
- Package riscv_mc_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, BRANCH, LUI, AUIPC.
  - Opcode constants.
  - ALU_ADD/ALU_SUB and other ALUControl codes.
  - ImmSrc and mux-select constants.
- Sub-module branch_cond: funct3 and flags in, taken out, purely combinational.
- ALUControl decode for EXECR/EXECI reuses the existing alu_decoder.

Test Plan:
- Reset: rst_n=0 mid-MEMWRITE -> same cycle MemWrite=0, state=FETCH. After release with mem_ready=1: IRWrite=1, PCWrite=1.
- add x3,x1,x2 (op 0110011) with mem_ready=1:
  - States FETCH,DECODE,EXECR,ALUWB.
  - RegWrite high only in cycle 4, ResultSrc=00.
- lw with mem_ready low 2 cycles in MEMREAD:
  - MEMREAD held 3 cycles, mem_req=1, AdrSrc=1.
  - Then MEMWB with RegWrite=1, ResultSrc=01.
- sw with mem_ready low 3 cycles: MemWrite=1 for exactly 4 cycles, never RegWrite.
- blt with N=1, V=0 -> PCWrite=1 in BRANCH. bgeu with C=1 -> PCWrite=0. Each takes 3 cycles.
- jalr: FETCH,DECODE,JALR,JAL,ALUWB; PCWrite in JAL. Opcode 0000000 -> illegal_instr one pulse in DECODE, back to FETCH.
